// File: rtl/quadrature_decoder_pkg.sv
// Shared types, Gray phase constants and direction helper for the quadrature decoder.
package quad_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } quad_state_t;

    // Gray phases in up-count order: 00 -> 01 -> 11 -> 10 -> 00
    localparam logic [1:0] PH_0 = 2'b00;
    localparam logic [1:0] PH_1 = 2'b01;
    localparam logic [1:0] PH_2 = 2'b11;
    localparam logic [1:0] PH_3 = 2'b10;

    // True when cur is the phase that follows prev in the up direction.
    function automatic logic is_up(input logic [1:0] prev, input logic [1:0] cur);
        logic up_s;
        case (prev)
            PH_0:    up_s = (cur == PH_1);
            PH_1:    up_s = (cur == PH_2);
            PH_2:    up_s = (cur == PH_3);
            PH_3:    up_s = (cur == PH_0);
            default: up_s = 1'b0;
        endcase
        return up_s;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Control/status bundle between the quadrature decoder and its host logic.
interface quadrature_decoder_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             step;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic             err;
    logic             err_sticky;

    modport master (
        output en, a_in, b_in, clr,
        input  step, dir, count, err, err_sticky
    );

    modport slave (
        input  en, a_in, b_in, clr,
        output step, dir, count, err, err_sticky
    );
endinterface

// File: rtl/quadrature_decoder_filter.sv
// One quadrature channel: metastability synchroniser followed by a run-length glitch filter.
module quad_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt,
    output logic quiet
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   filt_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Shift the asynchronous pad level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_r <= 1'b0;
            cnt_r  <= '0;
        end else if (synced_s != filt_r) begin
            if (cnt_r == CNT_LAST) begin
                filt_r <= synced_s;
                cnt_r  <= '0;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign filt  = filt_r;
    assign quiet = (cnt_r == '0);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered phases drive step/dir/err pulses and a wrapping position count.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    quadrature_decoder_if.slave  bus
);
    localparam int ICW = $clog2(FILTER_LEN + 1);
    localparam logic [ICW-1:0]   INIT_DONE = ICW'(FILTER_LEN);
    localparam logic [ICW-1:0]   INIT_ONE  = ICW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             a_filt_s, b_filt_s, a_quiet_s, b_quiet_s;
    logic [1:0]       cur_s, diff_s;
    logic             one_bit_s, two_bit_s, up_s;
    logic             step_next_s, err_next_s;

    quad_state_t      state_r;
    logic [ICW-1:0]   init_cnt_r;
    logic [1:0]       prev_r;
    logic             step_r, dir_r, err_r, sticky_r;
    logic [CNT_W-1:0] count_r;

    quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .rst(rst), .din(bus.a_in), .filt(a_filt_s), .quiet(a_quiet_s)
    );

    quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .rst(rst), .din(bus.b_in), .filt(b_filt_s), .quiet(b_quiet_s)
    );

    assign cur_s = {a_filt_s, b_filt_s};

    // Classify the phase change since last cycle and decide this cycle's pulses.
    always_comb begin
        diff_s    = cur_s ^ prev_r;
        one_bit_s = 1'b0;
        two_bit_s = 1'b0;
        case (diff_s)
            2'b01, 2'b10: one_bit_s = 1'b1;
            2'b11:        two_bit_s = 1'b1;
            default: begin
                one_bit_s = 1'b0;
                two_bit_s = 1'b0;
            end
        endcase
        up_s = is_up(prev_r, cur_s);
        if ((state_r == TRACK) && bus.en) begin
            step_next_s = one_bit_s;
            err_next_s  = two_bit_s;
        end else begin
            step_next_s = 1'b0;
            err_next_s  = 1'b0;
        end
    end

    // Startup: require the current cycle plus FILTER_LEN earlier ones quiet on both
    // filters, so a level still travelling through the synchroniser after reset is
    // absorbed into prev instead of being seen as motion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= INIT;
            init_cnt_r <= '0;
            prev_r     <= 2'b00;
        end else begin
            case (state_r)
                INIT: begin
                    if (a_quiet_s && b_quiet_s) begin
                        if (init_cnt_r == INIT_DONE) begin
                            prev_r     <= cur_s;
                            state_r    <= TRACK;
                            init_cnt_r <= '0;
                        end else begin
                            init_cnt_r <= init_cnt_r + INIT_ONE;
                        end
                    end else begin
                        init_cnt_r <= '0;
                    end
                end
                TRACK: begin
                    // prev follows the phase even while disabled so re-enable is silent
                    prev_r <= cur_s;
                end
                default: begin
                    state_r    <= INIT;
                    init_cnt_r <= '0;
                end
            endcase
        end
    end

    // Registered outputs: pulses, direction, position and sticky error; clr wins over motion.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r   <= 1'b0;
            err_r    <= 1'b0;
            dir_r    <= 1'b1;
            count_r  <= '0;
            sticky_r <= 1'b0;
        end else begin
            step_r <= step_next_s;
            err_r  <= err_next_s;
            if (step_next_s) begin
                dir_r <= up_s;
            end
            if (bus.clr) begin
                count_r  <= '0;
                sticky_r <= 1'b0;
            end else begin
                if (step_next_s) begin
                    count_r <= up_s ? (count_r + CNT_ONE) : (count_r - CNT_ONE);
                end
                if (err_next_s) begin
                    sticky_r <= 1'b1;
                end
            end
        end
    end

    assign bus.step       = step_r;
    assign bus.dir        = dir_r;
    assign bus.count      = count_r;
    assign bus.err        = err_r;
    assign bus.err_sticky = sticky_r;

endmodule
